// File: rtl/seq_fsm_4s1i1o_mo_if.sv
// Signal bundle for the four-state Moore recogniser.
// master: the block that feeds in_ and watches state/out.
// slave : the FSM itself.
// There is no handshake. in_ is consumed on every rising clock edge.
// state and out are valid for the whole cycle that follows that edge.
interface seq_fsm_4s1i1o_mo_if;
    logic       in_;
    logic [3:0] state;
    logic       out;

    modport master (
        output in_,
        input  state,
        input  out
    );

    modport slave (
        input  in_,
        output state,
        output out
    );
endinterface

// File: rtl/seq_fsm_4s1i1o_mo.sv
// Four-state, one-input, one-output Moore FSM with a one-hot state bus.
//   A=0001  B=0010  C=0100  D=1000
//   out=1 only in D.
// The output is decoded from the state register alone, so there is no
// combinational path from in_ to state or out.
// Optional macro SEQ_FSM_ILLEGAL_RECOVER_EN:
//   Any non-one-hot register value returns to A on the next edge.
//   out is held at 0 while the register is illegal.
//   Without the macro, illegal values are unreachable and never decoded.
module seq_fsm_4s1i1o_mo (
    input  logic                        clk,
    input  logic                        reset,
    seq_fsm_4s1i1o_mo_if.slave          bus
);

    typedef enum logic [3:0] {
        ST_A = 4'b0001,
        ST_B = 4'b0010,
        ST_C = 4'b0100,
        ST_D = 4'b1000
    } state_t;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       out_d;

    // State register: synchronous reset wins over the transition table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_A;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SEQ_FSM_ILLEGAL_RECOVER_EN
    // Next state and output from a full decode; non-one-hot values fall back to A.
    always_comb begin
        state_d = ST_A;
        out_d   = 1'b0;
        case (state_q)
            ST_A: state_d = bus.in_ ? ST_B : ST_A;
            ST_B: state_d = bus.in_ ? ST_B : ST_C;
            ST_C: state_d = bus.in_ ? ST_D : ST_A;
            ST_D: begin
                state_d = bus.in_ ? ST_B : ST_C;
                out_d   = 1'b1;
            end
            default: begin
                state_d = ST_A;
                out_d   = 1'b0;
            end
        endcase
    end
`else
    // Per-bit one-hot equations; legal states only, so each next bit ORs its incoming arcs.
    always_comb begin
        state_d    = 4'b0000;
        state_d[0] = ~bus.in_ & (state_q[0] | state_q[2]);
        state_d[1] =  bus.in_ & (state_q[0] | state_q[1] | state_q[3]);
        state_d[2] = ~bus.in_ & (state_q[1] | state_q[3]);
        state_d[3] =  bus.in_ &  state_q[2];
        out_d      = state_q[3];
    end
`endif

    assign bus.state = state_q;
    assign bus.out   = out_d;

endmodule

// File: tb/tb_seq_fsm_4s1i1o_mo.sv
// Scoreboard bench for seq_fsm_4s1i1o_mo.
// The driver applies in_/reset on the falling edge and pushes the expected
// {out, state} that the next rising edge must produce.
// The monitor pops one entry 1 ns after every rising edge and compares.
module tb_seq_fsm_4s1i1o_mo;

    localparam logic [3:0] S_A = 4'b0001;
    localparam logic [3:0] S_B = 4'b0010;
    localparam logic [3:0] S_C = 4'b0100;
    localparam logic [3:0] S_D = 4'b1000;

    logic clk;
    logic reset;

    seq_fsm_4s1i1o_mo_if bus ();

    seq_fsm_4s1i1o_mo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    logic [3:0] model_state;
    int         n_checks;
    int         n_fail;
    bit         drive_done;

    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic in_v);
        case (cur)
            S_A:     return in_v ? S_B : S_A;
            S_B:     return in_v ? S_B : S_C;
            S_C:     return in_v ? S_D : S_A;
            S_D:     return in_v ? S_B : S_C;
            default: return S_A;
        endcase
    endfunction

    // driver: one cycle of stimulus, plus the expected result after the next edge
    task automatic drive(input logic in_v, input logic rst_v);
        @(negedge clk);
        bus.in_ = in_v;
        reset   = rst_v;
        model_state = rst_v ? S_A : model_next(model_state, in_v);
        exp_q.push_back({(model_state == S_D), model_state});
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) drive(bits[i], 1'b0);
    endtask

    // monitor: compare the DUT against the scoreboard after each rising edge
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.state !== e[3:0]) begin
                    n_fail++;
                    $display("FAIL state: got %b expected %b at %0t", bus.state, e[3:0], $time);
                end
                n_checks++;
                if (bus.out !== e[4]) begin
                    n_fail++;
                    $display("FAIL out: got %b expected %b at %0t", bus.out, e[4], $time);
                end
                n_checks++;
                if (!$onehot(bus.state)) begin
                    n_fail++;
                    $display("FAIL onehot: got %b expected one bit set at %0t", bus.state, $time);
                end
            end
        end
    end

    // stimulus sequence
    initial begin
        int wait_cycles;
        n_checks    = 0;
        n_fail      = 0;
        drive_done  = 1'b0;
        model_state = S_A;
        bus.in_     = 1'b0;
        reset       = 1'b1;

        // reset state
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);

        // main sequence 0,1,1,0,0,1,0,1,0,1,0,0,0
        drive_seq(16'b0110010101000, 13);

        // A -> D via 1,0,1 then 1 -> B (D->B arc)
        drive_seq(16'b1011, 4);

        // reach D, reset with in_=0, then 0,1,1,0
        drive(1'b0, 1'b1);
        drive_seq(16'b101, 3);
        drive(1'b0, 1'b1);
        drive_seq(16'b0110, 4);

        // in C: reset with in_=1 beats C->D
        drive(1'b1, 1'b1);
        drive_seq(16'b10, 2);
        drive(1'b1, 1'b1);

        // random in_ for 40 cycles
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 1'b0);

        // random reset and in_ for 20 cycles
        for (int i = 0; i < 20; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));

`ifdef SEQ_FSM_ILLEGAL_RECOVER_EN
        // corrupt the register to 0110; out must be 0, next edge must give A
        drive(1'b0, 1'b0);
        @(negedge clk);
        force dut.state_q = 4'b0110;
        #1;
        release dut.state_q;
        #1;
        n_checks++;
        if (bus.out !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_out: got %b expected 0 at %0t", bus.out, $time);
        end
        bus.in_ = 1'b1;
        reset   = 1'b0;
        model_state = S_A;
        exp_q.push_back({1'b0, S_A});
        drive(1'b1, 1'b0);
`endif

        drive(1'b0, 1'b0);
        drive_done = 1'b1;

        // drain: every expected entry must be consumed within a bounded number of cycles
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
